// File: rtl/sat_arith_pkg.sv
// Shared helpers for the saturating add/sub datapath: range limits and
// overflow flag bundle carried between pipeline stages.
package sat_arith_pkg;

   function automatic logic [31:0] sat_max(input int unsigned w);
      return (32'd1 << (w - 1)) - 32'd1;
   endfunction

   function automatic logic [31:0] sat_min(input int unsigned w);
      return 32'd1 << (w - 1);
   endfunction

   typedef struct packed {
      logic ovf_plus;
      logic ovf_minus;
   } ovf_flags_t;

endpackage

// File: rtl/sat_sub_core.sv
// Combinational wraparound subtractor with signed overflow detection.
module sat_sub_core #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] raw,
   output logic         ovf_plus,
   output logic         ovf_minus
);

   assign raw       = a - b;
   // Overflow is only possible when the operand signs differ.
   assign ovf_plus  = ~a[W-1] &  b[W-1] &  raw[W-1];
   assign ovf_minus =  a[W-1] & ~b[W-1] & ~raw[W-1];

endmodule

// File: rtl/signed_sub_with_saturation_pipe.sv
// Two-stage valid/ready pipelined saturating subtractor (diff = a - b)
// with a saturating count of clamped results delivered downstream.
module signed_sub_with_saturation_pipe
   import sat_arith_pkg::*;
#(
   parameter int W     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic             down_valid,
   input  logic             down_ready,
   output logic [W-1:0]     diff,
   output logic             sat_hi,
   output logic             sat_lo,
   input  logic             clr_count,
   output logic [CNT_W-1:0] sat_count
);

   localparam logic [W-1:0] MAX_V = W'(sat_max(W));
   localparam logic [W-1:0] MIN_V = W'(sat_min(W));

   typedef struct packed {
      logic [W-1:0] raw;
      ovf_flags_t   ovf;
   } s1_payload_t;

   logic [W-1:0] core_raw;
   logic         core_ovf_plus;
   logic         core_ovf_minus;
   s1_payload_t  core_pay;

   logic        s1_valid_q, s1_valid_d;
   s1_payload_t s1_pay_q, s1_pay_d;
   logic        s2_valid_q, s2_valid_d;
   logic [W-1:0] diff_q, diff_d;
   logic        sat_hi_q, sat_hi_d;
   logic        sat_lo_q, sat_lo_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic         s1_accept;
   logic         s2_accept;
   logic [W-1:0] sat_diff;

   sat_sub_core #(.W(W)) u_core (
      .a        (a),
      .b        (b),
      .raw      (core_raw),
      .ovf_plus (core_ovf_plus),
      .ovf_minus(core_ovf_minus)
   );

   assign core_pay = '{raw: core_raw, ovf: '{ovf_plus: core_ovf_plus, ovf_minus: core_ovf_minus}};

   assign s2_accept = ~s2_valid_q | down_ready;
   assign s1_accept = ~s1_valid_q | s2_accept;
   assign up_ready  = s1_accept;

   assign sat_diff = s1_pay_q.ovf.ovf_plus  ? MAX_V :
                     s1_pay_q.ovf.ovf_minus ? MIN_V : s1_pay_q.raw;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_pay_d   = s1_pay_q;
      s2_valid_d = s2_valid_q;
      diff_d     = diff_q;
      sat_hi_d   = sat_hi_q;
      sat_lo_d   = sat_lo_q;
      count_d    = count_q;

      if (s1_accept) begin
         s1_valid_d = up_valid;
         if (up_valid) s1_pay_d = core_pay;
      end

      // A stage 1 bubble still advances, clearing s2_valid once it drains.
      if (s2_accept) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            diff_d   = sat_diff;
            sat_hi_d = s1_pay_q.ovf.ovf_plus;
            sat_lo_d = s1_pay_q.ovf.ovf_minus;
         end
      end

      if (clr_count) begin
         count_d = '0;
      end else if (s2_valid_q && down_ready && (sat_hi_q || sat_lo_q) && !(&count_q)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_pay_q   <= '0;
         s2_valid_q <= 1'b0;
         diff_q     <= '0;
         sat_hi_q   <= 1'b0;
         sat_lo_q   <= 1'b0;
         count_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_pay_q   <= s1_pay_d;
         s2_valid_q <= s2_valid_d;
         diff_q     <= diff_d;
         sat_hi_q   <= sat_hi_d;
         sat_lo_q   <= sat_lo_d;
         count_q    <= count_d;
      end
   end

   assign down_valid = s2_valid_q;
   assign diff       = diff_q;
   assign sat_hi     = sat_hi_q;
   assign sat_lo     = sat_lo_q;
   assign sat_count  = count_q;

endmodule

// File: doc/signed_sub_with_saturation_pipe.md
Name: signed_sub_with_saturation_pipe

Overview:
- Pipelined signed subtractor with saturation: diff = a - b, clamped to the W-bit two's-complement range.
- Counterpart to the saturating adder in the arithmetic datapath; completes the add/sub pair used by the accumulate/compare pipelines.
- Two register stages with valid/ready on both sides.
- Counts saturation events for debug/status readout.

Parameters:
- W, 4, operand and result width (signed two's complement), W >= 2.
- CNT_W, 8, width of the saturation event counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- up_valid  input  1  operand pair valid.
- up_ready  output  1  block can accept an operand pair this cycle.
- a  input  W  minuend, signed.
- b  input  W  subtrahend, signed.
- down_valid  output  1  result valid.
- down_ready  input  1  consumer accepts result.
- diff  output  W  saturated a - b, signed.
- sat_hi  output  1  result clamped to max positive (qualified by down_valid).
- sat_lo  output  1  result clamped to min negative (qualified by down_valid).
- clr_count  input  1  synchronous clear of sat_count.
- sat_count  output  CNT_W  number of saturated results delivered, saturating counter.

Behaviour:
- Reset (rst_n low at a rising clk edge):
  - s1_valid, s2_valid, down_valid, diff, sat_hi, sat_lo and sat_count all 0.
  - up_ready is 1 in the cycle after reset.
  - Reset mid-operation discards all in-flight data; no partial output is produced.
- Arithmetic, W-bit wraparound:
  - raw = a - b.
  - ovf_plus = ~a[W-1] & b[W-1] & raw[W-1], i.e. non-negative minus negative giving a negative result.
  - ovf_minus = a[W-1] & ~b[W-1] & ~raw[W-1], i.e. negative minus non-negative giving a non-negative result.
  - diff = ovf_plus ? MAX (0 followed by W-1 ones) : ovf_minus ? MIN (1 followed by W-1 zeros) : raw.
  - sat_hi = ovf_plus; sat_lo = ovf_minus; the two are never both 1.
  - Corner: 0 - MIN saturates to MAX. MIN - MIN = 0 with no saturation.
- Stage 1:
  - Registers raw, ovf_plus and ovf_minus on an up handshake (up_valid & up_ready); sets s1_valid.
- Stage 2:
  - Registers the saturated diff, sat_hi and sat_lo when s1_valid and stage 2 can accept.
  - down_valid = s2_valid.
- Flow control:
  - s2 can accept = ~s2_valid | down_ready.
  - s1 can accept = ~s1_valid | s2 can accept.
  - up_ready = s1 can accept. Combinational from down_ready; no combinational path from up_valid to up_ready.
- Latency and throughput:
  - Latency is 2 cycles from up handshake to down_valid when down_ready stays high.
  - Full throughput is 1 result per cycle.
- Stall:
  - With down_ready low and both stages full, up_ready = 0.
  - diff, sat_hi, sat_lo and down_valid stay stable until handshake.
  - No data is dropped or duplicated, and order is preserved.
- Bubbles:
  - A stage 1 bubble (s1_valid = 0) moves forward and clears s2_valid once stage 2 drains.
- sat_count:
  - Increments on every down handshake (down_valid & down_ready) with sat_hi | sat_lo.
  - Holds at all-ones (no wrap).
  - clr_count has priority: clear and increment in the same cycle gives 0.
- Output registers hold their last values while not valid; the bench checks them only when down_valid = 1.

Decomposition:
- Shared package sat_arith_pkg:
  - function sat_max(W) and function sat_min(W) returning the MAX/MIN constants.
  - typedef for the stage payload struct {raw, ovf_plus, ovf_minus}.
- Sub-module sat_sub_core, purely combinational:
  - inputs a, b; outputs raw, ovf_plus, ovf_minus.
  - Instantiated ahead of stage 1.
  - Saturation mux sits ahead of stage 2 in the top module.

Test Plan:
- Reset, then stream with down_ready = 1: (3,5), (-1,7), (-8,-8), (1,-2) -> diff -2, -8, 0, 3 on consecutive cycles starting 2 cycles after the first handshake; no sat flags; sat_count = 0.
- Positive overflow: (7,-1), (0,-8), (4,-4) -> diff 7, 7, 7 with sat_hi = 1 each; sat_count = 3.
- Negative overflow: (-2,7), (-8,1), (-5,4) -> diff -8, -8, -8 with sat_lo = 1; (-1,7) -> -8 with no flag.
- Back-pressure: issue 4 pairs, hold down_ready = 0 for 5 cycles -> up_ready drops after 2 accepted, outputs stable, then all 4 results appear in order with none lost.
- Counter: 300 saturating results with CNT_W = 8 -> sat_count holds at 255; clr_count asserted together with a saturating handshake -> 0.
- Reset mid-stream: assert rst_n = 0 with both stages full -> next cycle down_valid = 0, sat_count = 0, up_ready = 1; the next pair (2,1) -> diff 1 after 2 cycles.
